// File: rtl/cmp_result_monitor.sv
// Windowed statistics over comparator result flags: per-class counts, malformed-flag
// count and longest Greater run, reported once every WINDOW accepted results.
module cmp_result_monitor #(
  parameter int WINDOW = 256,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             Equal,
  input  logic             Greater,
  input  logic             Less,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] eq_cnt,
  output logic [CNT_W-1:0] gt_cnt,
  output logic [CNT_W-1:0] lt_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] gt_run_max
);

  localparam logic [0:0] ACCUM  = 1'b0;
  localparam logic [0:0] REPORT = 1'b1;
  localparam logic [CNT_W-1:0] WIN = CNT_W'(WINDOW);

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] eq_q, eq_d, gt_q, gt_d, lt_q, lt_d, err_q, err_d;
  logic [CNT_W-1:0] smp_q, smp_d, run_q, run_d, rmax_q, rmax_d;
  logic [CNT_W-1:0] oeq_q, oeq_d, ogt_q, ogt_d, olt_q, olt_d, oerr_q, oerr_d;
  logic [CNT_W-1:0] ormax_q, ormax_d;

  logic             one_hot, g_ok;
  logic [CNT_W-1:0] eq_nx, gt_nx, lt_nx, err_nx, smp_nx, run_nx, rmax_nx;

  always_comb begin
    one_hot = ({Equal, Greater, Less} == 3'b100) || ({Equal, Greater, Less} == 3'b010) ||
              ({Equal, Greater, Less} == 3'b001);
    g_ok    = one_hot & Greater;
    eq_nx   = eq_q  + CNT_W'(one_hot & Equal);
    gt_nx   = gt_q  + CNT_W'(g_ok);
    lt_nx   = lt_q  + CNT_W'(one_hot & Less);
    err_nx  = err_q + CNT_W'(!one_hot);
    smp_nx  = smp_q + CNT_W'(1);
    run_nx  = g_ok ? run_q + CNT_W'(1) : '0;
    rmax_nx = (run_nx > rmax_q) ? run_nx : rmax_q;
  end

  always_comb begin
    state_d = state_q;
    eq_d    = eq_q;
    gt_d    = gt_q;
    lt_d    = lt_q;
    err_d   = err_q;
    smp_d   = smp_q;
    run_d   = run_q;
    rmax_d  = rmax_q;
    oeq_d   = oeq_q;
    ogt_d   = ogt_q;
    olt_d   = olt_q;
    oerr_d  = oerr_q;
    ormax_d = ormax_q;
    case (state_q)
      ACCUM: begin
        if (clear) begin
          {eq_d, gt_d, lt_d, err_d, smp_d, run_d, rmax_d} = '0;
        end else if (in_valid) begin
          if (smp_nx == WIN) begin
            // Final sample goes straight to the report registers; accumulators restart at zero.
            oeq_d   = eq_nx;
            ogt_d   = gt_nx;
            olt_d   = lt_nx;
            oerr_d  = err_nx;
            ormax_d = rmax_nx;
            {eq_d, gt_d, lt_d, err_d, smp_d, run_d, rmax_d} = '0;
            state_d = REPORT;
          end else begin
            eq_d   = eq_nx;
            gt_d   = gt_nx;
            lt_d   = lt_nx;
            err_d  = err_nx;
            smp_d  = smp_nx;
            run_d  = run_nx;
            rmax_d = rmax_nx;
          end
        end
      end
      default: begin
        if (clear) begin
          {eq_d, gt_d, lt_d, err_d, smp_d, run_d, rmax_d} = '0;
          state_d = ACCUM;
        end else if (out_ready) begin
          state_d = ACCUM;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      eq_q    <= '0;
      gt_q    <= '0;
      lt_q    <= '0;
      err_q   <= '0;
      smp_q   <= '0;
      run_q   <= '0;
      rmax_q  <= '0;
      oeq_q   <= '0;
      ogt_q   <= '0;
      olt_q   <= '0;
      oerr_q  <= '0;
      ormax_q <= '0;
    end else begin
      state_q <= state_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
      err_q   <= err_d;
      smp_q   <= smp_d;
      run_q   <= run_d;
      rmax_q  <= rmax_d;
      oeq_q   <= oeq_d;
      ogt_q   <= ogt_d;
      olt_q   <= olt_d;
      oerr_q  <= oerr_d;
      ormax_q <= ormax_d;
    end
  end

  assign in_ready   = (state_q == ACCUM);
  assign out_valid  = (state_q == REPORT);
  assign eq_cnt     = oeq_q;
  assign gt_cnt     = ogt_q;
  assign lt_cnt     = olt_q;
  assign err_cnt    = oerr_q;
  assign gt_run_max = ormax_q;

endmodule

// File: tb/tb_cmp_result_monitor.sv
// Scoreboard bench: window reports from a queue-based reference model are
// compared against the DUT whenever it presents a report.
module tb_cmp_result_monitor;

  localparam int W = 4;

  typedef struct packed {
    logic [15:0] eq;
    logic [15:0] gt;
    logic [15:0] lt;
    logic [15:0] err;
    logic [15:0] rmax;
  } rep_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, Equal = 1'b0, Greater = 1'b0, Less = 1'b0;
  logic clear = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid;
  logic [15:0] eq_cnt, gt_cnt, lt_cnt, err_cnt, gt_run_max;

  logic b_in_valid = 1'b0, b_Equal = 1'b0, b_Greater = 1'b0, b_Less = 1'b0;
  logic b_clear = 1'b0, b_out_ready = 1'b0;
  logic b_in_ready, b_out_valid;
  logic [15:0] b_eq, b_gt, b_lt, b_err, b_rmax;

  int checks = 0;
  int passes = 0;

  logic [2:0] win[$];
  rep_t       expq[$];
  logic       m_accum = 1'b1;

  always #5 clk = ~clk;

  cmp_result_monitor #(.WINDOW(W), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .Equal(Equal), .Greater(Greater), .Less(Less), .clear(clear),
    .out_valid(out_valid), .out_ready(out_ready), .eq_cnt(eq_cnt), .gt_cnt(gt_cnt),
    .lt_cnt(lt_cnt), .err_cnt(err_cnt), .gt_run_max(gt_run_max)
  );

  cmp_result_monitor #(.WINDOW(256), .CNT_W(16)) u_dut256 (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .Equal(b_Equal), .Greater(b_Greater), .Less(b_Less), .clear(b_clear),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .eq_cnt(b_eq), .gt_cnt(b_gt),
    .lt_cnt(b_lt), .err_cnt(b_err), .gt_run_max(b_rmax)
  );

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passes++;
  endtask

  // Flags are {E,G,L}; a sample is valid only when exactly one flag is set.
  function automatic rep_t ref_report(input logic [2:0] s[$]);
    int eq = 0, gt = 0, lt = 0, err = 0, run = 0, mx = 0;
    rep_t r;
    foreach (s[i]) begin
      if ($countones(s[i]) != 1) begin
        err++;
        run = 0;
      end else if (s[i] == 3'b010) begin
        gt++;
        run++;
        if (run > mx) mx = run;
      end else begin
        if (s[i] == 3'b100) eq++;
        else lt++;
        run = 0;
      end
    end
    r.eq = 16'(eq); r.gt = 16'(gt); r.lt = 16'(lt); r.err = 16'(err); r.rmax = 16'(mx);
    return r;
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_accum = 1'b1;
      win.delete();
      expq.delete();
    end else if (m_accum) begin
      if (clear) win.delete();
      else if (in_valid) begin
        win.push_back({Equal, Greater, Less});
        if (win.size() == W) begin
          expq.push_back(ref_report(win));
          win.delete();
          m_accum = 1'b0;
        end
      end
    end else if (clear || out_ready) begin
      m_accum = 1'b1;
    end
  end

  initial begin : monitor
    logic have;
    rep_t cur;
    have = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) have = 1'b0;
      else begin
        chk("in_ready", 80'(in_ready), 80'(m_accum));
        chk("out_valid", 80'(out_valid), 80'(!m_accum));
        if (out_valid) begin
          if (!have) begin
            if (expq.size() == 0) chk("report_expected", 80'(0), 80'(1));
            else begin
              cur = expq.pop_front();
              have = 1'b1;
            end
          end
          if (have) chk("report", {eq_cnt, gt_cnt, lt_cnt, err_cnt, gt_run_max}, cur);
        end else have = 1'b0;
      end
    end
  end

  task automatic cyc(input logic v, input logic [2:0] f, input logic rdy, input logic clr);
    @(negedge clk);
    in_valid = v;
    {Equal, Greater, Less} = f;
    out_ready = rdy;
    clear = clr;
  endtask

  task automatic wait_rep(input string name);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 3'b000, 1'b0, 1'b0);
      if (out_valid) return;
    end
    chk({name, "_timeout"}, 80'(0), 80'(1));
  endtask

  task automatic release_rep();
    cyc(1'b0, 3'b000, 1'b1, 1'b0);
    cyc(1'b0, 3'b000, 1'b0, 1'b0);
  endtask

  task automatic bsend(input logic [2:0] f);
    @(negedge clk);
    b_in_valid = 1'b1;
    {b_Equal, b_Greater, b_Less} = f;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_ready_valid", {78'(0), in_ready, out_valid}, 80'b10);
    chk("reset_counts", {eq_cnt, gt_cnt, lt_cnt, err_cnt, gt_run_max}, 80'(0));
    rst_n = 1'b1;

    // G,G,E,G then hold report with in_valid high and no out_ready
    cyc(1, 3'b010, 0, 0); cyc(1, 3'b010, 0, 0); cyc(1, 3'b100, 0, 0); cyc(1, 3'b010, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 3'($urandom_range(0, 7)), 1'b0, 1'b0);
      chk("hold_valid_ready", {78'(0), out_valid, in_ready}, 80'b10);
      chk("hold_counts", {eq_cnt, gt_cnt, lt_cnt, err_cnt, gt_run_max},
          {16'd1, 16'd3, 16'd0, 16'd0, 16'd2});
    end
    release_rep();
    chk("back_to_accum", 80'(in_ready), 80'(1));

    // E, {E,G}, none, L
    cyc(1, 3'b100, 0, 0); cyc(1, 3'b110, 0, 0); cyc(1, 3'b000, 0, 0); cyc(1, 3'b001, 0, 0);
    wait_rep("err_window");
    chk("err_window", {eq_cnt, gt_cnt, lt_cnt, err_cnt, gt_run_max},
        {16'd1, 16'd0, 16'd1, 16'd2, 16'd0});
    release_rep();

    // clear mid-window discards partial samples and a simultaneous input
    cyc(1, 3'b010, 0, 0); cyc(1, 3'b100, 0, 0); cyc(1, 3'b010, 0, 1);
    for (int i = 0; i < 4; i++) cyc(1, 3'b001, 0, 0);
    wait_rep("clear_window");
    chk("clear_window", {eq_cnt, gt_cnt, lt_cnt, err_cnt, gt_run_max},
        {16'd0, 16'd0, 16'd4, 16'd0, 16'd0});

    // asynchronous reset while a report is pending
    #2 rst_n = 1'b0;
    #1 chk("async_rst_flags", {78'(0), in_ready, out_valid}, 80'b10);
    chk("async_rst_counts", {eq_cnt, gt_cnt, lt_cnt, err_cnt, gt_run_max}, 80'(0));
    cyc(0, 3'b000, 0, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
          1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 24) == 0));
    for (int i = 0; i < 4; i++) cyc(0, 3'b000, 1, 0);
    cyc(0, 3'b000, 0, 0);
    chk("drain_queue", 80'(expq.size()), 80'(0));

    // WINDOW=256: full run of Greater, then a window that must start with run state 0
    for (int i = 0; i < 256; i++) bsend(3'b010);
    @(negedge clk); b_in_valid = 1'b0;
    chk("w256_valid", 80'(b_out_valid), 80'(1));
    chk("w256_all_g", {b_eq, b_gt, b_lt, b_err, b_rmax},
        {16'd0, 16'd256, 16'd0, 16'd0, 16'd256});
    b_out_ready = 1'b1;
    @(negedge clk); b_out_ready = 1'b0;
    chk("w256_accum", 80'(b_in_ready), 80'(1));
    for (int i = 0; i < 255; i++) bsend(3'b010);
    bsend(3'b001);
    @(negedge clk); b_in_valid = 1'b0;
    chk("w256_second", {b_eq, b_gt, b_lt, b_err, b_rmax},
        {16'd0, 16'd255, 16'd1, 16'd0, 16'd255});

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
